uart_note_player: RTL and testbench

- Consumes bytes from the UART receiver and turns them into a timed note stream for the Beeper block.
- Drives Beeper's 8-bit tone selector and its tone enable.
- Buffers incoming (tone, duration) byte pairs in an internal FIFO and plays them back in order, timed by the 1 ms divider output.
- Sits between uart_recv/divide (upstream) and Beeper (downstream).

---
 rtl/uart_note_player.sv | 209 ++++++++++++++++++++
 tb/tb_uart_note_player.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_note_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_note_player : buffers UART (tone, duration) byte pairs and plays them to Beeper
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_note_player #(
  parameter int         FIFO_DEPTH      = 16,
  parameter int         UNIT_MS         = 10,
  parameter int         PAIR_TIMEOUT_MS = 100,
  parameter logic [7:0] CMD_FLUSH       = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done_i,
  input  logic [7:0] uart_data_i,
  input  logic       clk_1ms_i,
  input  logic       play_en_i,
  output logic [7:0] music_tone_o,
  output logic       tone_en_o,
  output logic       playing_o,
  output logic       fifo_full_o,
  output logic       overflow_o,
  output logic       note_toggle_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(UNIT_MS + 1);
  localparam int TW = $clog2(PAIR_TIMEOUT_MS + 1);

  localparam logic [CW-1:0] c_DEPTH   = CW'(FIFO_DEPTH);
  localparam logic [MW-1:0] c_MS_LAST = MW'(UNIT_MS - 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(PAIR_TIMEOUT_MS - 1);

  localparam logic       c_PH_TONE = 1'b0;
  localparam logic       c_PH_DUR  = 1'b1;
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_PLAY = 2'd2;

  logic [2:0]    done_sync_q, tick_sync_q;
  logic          w_byte_stb, w_tick;
  logic          phase_q;
  logic [7:0]    pend_tone_q;
  logic [TW-1:0] to_cnt_q;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   head_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full_q, overflow_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    units_q;
  logic [MW-1:0] ms_q;
  logic [7:0]    music_tone_q;
  logic          tone_en_q, note_toggle_q;
  logic          w_is_flush, w_push_req, w_full_now, w_push;
  logic          w_can_pop, w_note_end, w_pop, w_load, w_playing;

  // Two-flop synchronisers; third stage only provides the previous value for edge detect
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_sync_q <= '0;
      tick_sync_q <= '0;
    end else begin
      done_sync_q <= {done_sync_q[1:0], uart_done_i};
      tick_sync_q <= {tick_sync_q[1:0], clk_1ms_i};
    end
  end

  assign w_byte_stb = done_sync_q[1] & ~done_sync_q[2];
  assign w_tick     = tick_sync_q[1] & ~tick_sync_q[2];

  assign w_is_flush = w_byte_stb & (phase_q == c_PH_TONE) & (uart_data_i == CMD_FLUSH);
  assign w_push_req = w_byte_stb & (phase_q == c_PH_DUR) & (uart_data_i != 8'd0);
  assign w_full_now = (count_q == c_DEPTH);
  assign w_push     = w_push_req & ~w_full_now;
  assign w_can_pop  = (count_q != '0) & play_en_i & ~w_is_flush;
  assign w_note_end = (state_q == c_ST_PLAY) & w_tick & play_en_i &
                      (ms_q == c_MS_LAST) & (units_q == 8'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_q     <= c_PH_TONE;
      pend_tone_q <= '0;
      to_cnt_q    <= '0;
    end else if (w_byte_stb) begin
      if (phase_q == c_PH_DUR) begin
        phase_q <= c_PH_TONE;
      end else if (!w_is_flush) begin
        phase_q     <= c_PH_DUR;
        pend_tone_q <= uart_data_i;
        to_cnt_q    <= '0;
      end
    end else if ((phase_q == c_PH_DUR) && w_tick) begin
      if (to_cnt_q == c_TO_LAST) phase_q <= c_PH_TONE;
      else                       to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {pend_tone_q, uart_data_i};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
      fifo_full_q <= 1'b0;
    end else begin
      fifo_full_q <= (count_q == c_DEPTH);
      if (w_is_flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (w_pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
          head_q   <= mem_q[rd_ptr_q];
        end
        if (w_push && !w_pop)      count_q <= count_q + CW'(1);
        else if (!w_push && w_pop) count_q <= count_q - CW'(1);
        if (w_push_req && w_full_now) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= c_ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_can_pop) state_d = c_ST_LOAD;
      c_ST_LOAD: state_d = c_ST_PLAY;
      c_ST_PLAY: if (w_note_end) state_d = w_can_pop ? c_ST_LOAD : c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
    if (w_is_flush) state_d = c_ST_IDLE;
  end

  always_comb begin
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_playing = 1'b0;
    case (state_q)
      c_ST_IDLE: w_pop = w_can_pop;
      c_ST_LOAD: begin
        w_load    = 1'b1;
        w_playing = 1'b1;
      end
      c_ST_PLAY: begin
        w_playing = 1'b1;
        w_pop     = w_note_end & w_can_pop;
      end
      default: ;
    endcase
  end

  // Outputs are loaded at the LOAD->PLAY edge so they are valid in the first PLAY cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      units_q       <= '0;
      ms_q          <= '0;
      music_tone_q  <= '0;
      tone_en_q     <= 1'b0;
      note_toggle_q <= 1'b0;
    end else if (w_is_flush) begin
      music_tone_q <= '0;
      tone_en_q    <= 1'b0;
    end else if (w_load) begin
      units_q       <= head_q[7:0];
      ms_q          <= '0;
      music_tone_q  <= head_q[15:8];
      tone_en_q     <= (head_q[15:8] != 8'd0) & play_en_i;
      note_toggle_q <= ~note_toggle_q;
    end else if (state_q == c_ST_PLAY) begin
      if (w_tick && play_en_i) begin
        if (ms_q == c_MS_LAST) begin
          ms_q    <= '0;
          units_q <= units_q - 8'd1;
        end else begin
          ms_q <= ms_q + MW'(1);
        end
      end
      if (w_note_end && !w_can_pop) begin
        music_tone_q <= '0;
        tone_en_q    <= 1'b0;
      end else begin
        tone_en_q <= (music_tone_q != 8'd0) & play_en_i;
      end
    end
  end

  assign music_tone_o  = music_tone_q;
  assign tone_en_o     = tone_en_q;
  assign playing_o     = w_playing;
  assign fifo_full_o   = fifo_full_q;
  assign overflow_o    = overflow_q;
  assign note_toggle_o = note_toggle_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_note_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_note_player : scoreboard bench; expected note segments queued, monitor compares
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_note_player;

  logic       sys_clk     = 1'b0;
  logic       sys_rst_n   = 1'b0;
  logic       uart_done_i = 1'b0;
  logic [7:0] uart_data_i = 8'd0;
  logic       clk_1ms_i   = 1'b0;
  logic       play_en_i   = 1'b0;
  logic [7:0] music_tone_o;
  logic       tone_en_o, playing_o, fifo_full_o, overflow_o, note_toggle_o;

  int n_vec    = 0;
  int n_err    = 0;
  int tick_cnt = 0;
  int n_tog    = 0;
  int n_fall   = 0;

  typedef struct {
    int tone;
    int en;
    int len;
  } exp_t;
  exp_t exp_q[$];

  uart_note_player #(
    .FIFO_DEPTH     (16),
    .UNIT_MS        (10),
    .PAIR_TIMEOUT_MS(100),
    .CMD_FLUSH      (8'hFF)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_done_i  (uart_done_i),
    .uart_data_i  (uart_data_i),
    .clk_1ms_i    (clk_1ms_i),
    .play_en_i    (play_en_i),
    .music_tone_o (music_tone_o),
    .tone_en_o    (tone_en_o),
    .playing_o    (playing_o),
    .fifo_full_o  (fifo_full_o),
    .overflow_o   (overflow_o),
    .note_toggle_o(note_toggle_o)
  );

  always #5 sys_clk = ~sys_clk;

  // 1 ms tick every 10 clocks; tick_cnt steps on the edge where the DUT consumes the tick
  initial begin
    forever begin
      @(posedge sys_clk); #1 clk_1ms_i = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 tick_cnt++;
      clk_1ms_i = 1'b0;
      repeat (6) @(posedge sys_clk);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: a segment opens on a note start or a tone_en change while playing, closes on the next
  initial begin : monitor
    logic pt, pe, pp, op, ea, eb, ec;
    int   ct, ce, t0;
    exp_t e;
    pt = 1'b0; pe = 1'b0; pp = 1'b0; op = 1'b0;
    ct = 0; ce = 0; t0 = 0;
    forever begin
      @(negedge sys_clk);
      ea = playing_o && (note_toggle_o != pt);
      eb = playing_o && pp && (tone_en_o != pe) && !ea;
      ec = pp && !playing_o;
      if (op && (ea || eb || ec)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL seg_unexpected: got tone %0d en %0d ticks %0d, required no note",
                   ct, ce, tick_cnt - t0);
        end else begin
          e = exp_q.pop_front();
          chk("seg_tone", ct, e.tone);
          chk("seg_en", ce, e.en);
          if (e.len >= 0) chk("seg_ticks", tick_cnt - t0, e.len);
        end
        op = 1'b0;
      end
      if (ea || eb) begin
        op = 1'b1;
        ct = music_tone_o;
        ce = tone_en_o;
        t0 = tick_cnt;
      end
      if (ea) n_tog++;
      if (ec) n_fall++;
      pt = note_toggle_o;
      pe = tone_en_o;
      pp = playing_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    uart_data_i = b;
    uart_done_i = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 uart_done_i = 1'b0;
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic push_exp(input int tone, input int en, input int len);
    exp_t e;
    e.tone = tone;
    e.en   = en;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input string nm, input int old);
    for (int k = 0; k < 400; k++) begin
      @(negedge sys_clk); #1;
      if (n_tog != old) break;
    end
    chk(nm, n_tog, old + 1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !playing_o) break;
      @(negedge sys_clk); #1;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_cnt;
    while (tick_cnt < t + n) @(tick_cnt);
  endtask

  initial begin
    int tog, fall, t0;

    repeat (3) @(negedge sys_clk);
    chk("rst_tone", music_tone_o, 0);
    chk("rst_en", tone_en_o, 0);
    chk("rst_playing", playing_o, 0);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_toggle", note_toggle_o, 0);
    sys_rst_n = 1'b1;
    play_en_i = 1'b1;
    repeat (3) @(posedge sys_clk);

    // Single note 5 x 3 units, with write-to-output latency
    tog = n_tog;
    push_exp(5, 1, 30);
    send_byte(8'h05);
    @(posedge sys_clk); #1;
    uart_data_i = 8'h03;
    uart_done_i = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("lat_w2_tone", music_tone_o, 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("lat_w3_tone", music_tone_o, 5);
    chk("lat_w3_en", tone_en_o, 1);
    uart_done_i = 1'b0;
    wait_drain("t1_drain", 800);
    chk("t1_toggles", n_tog, tog + 1);
    chk("t1_end_tone", music_tone_o, 0);

    // Back-to-back notes including a rest
    tog  = n_tog;
    fall = n_fall;
    push_exp(2, 1, 10);
    push_exp(0, 0, 20);
    push_exp(7, 1, 10);
    send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h07); send_byte(8'h01);
    wait_drain("t2_drain", 1000);
    chk("t2_toggles", n_tog, tog + 3);
    chk("t2_no_gap", n_fall, fall + 1);

    // Fill FIFO while paused, overflow, then play all
    play_en_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      send_byte(8'(k));
      send_byte(8'h01);
      if (k == 15) chk("t3_full_at15", fifo_full_o, 0);
      if (k == 16) begin
        chk("t3_full_at16", fifo_full_o, 1);
        chk("t3_ovf_at16", overflow_o, 0);
      end
    end
    chk("t3_ovf_at17", overflow_o, 1);
    chk("t3_full_at17", fifo_full_o, 1);
    for (int k = 1; k <= 16; k++) push_exp(k, 1, 10);
    tog = n_tog;
    play_en_i = 1'b1;
    wait_drain("t3_drain", 3000);
    chk("t3_notes", n_tog, tog + 16);
    chk("t3_full_after", fifo_full_o, 0);
    chk("t3_ovf_sticky", overflow_o, 1);
    send_byte(8'hFF);
    chk("t3_ovf_flushed", overflow_o, 0);

    // Abandoned tone byte after pair timeout
    send_byte(8'h04);
    wait_ticks(150);
    push_exp(6, 1, 20);
    send_byte(8'h06);
    send_byte(8'h02);
    wait_drain("t4_drain", 800);

    // Pause for 50 ticks after 12 ticks of a 30-tick note
    push_exp(5, 1, 12);
    push_exp(5, 0, 50);
    push_exp(5, 1, 18);
    tog = n_tog;
    send_byte(8'h05);
    send_byte(8'h03);
    wait_start("t5_start", tog);
    t0 = tick_cnt;
    while (tick_cnt < t0 + 12) @(tick_cnt);
    play_en_i = 1'b0;
    while (tick_cnt < t0 + 62) @(tick_cnt);
    @(negedge sys_clk);
    chk("t5_paused_en", tone_en_o, 0);
    chk("t5_paused_tone", music_tone_o, 5);
    while (tick_cnt < t0 + 62) @(tick_cnt);
    play_en_i = 1'b1;
    wait_drain("t5_drain", 800);

    // Asynchronous reset mid-note (23 notes so far, so note_toggle is 1)
    push_exp(9, 1, -1);
    tog = n_tog;
    send_byte(8'h09);
    send_byte(8'h04);
    wait_start("t6_start", tog);
    wait_ticks(5);
    chk("t6_toggle_before", note_toggle_o, 1);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_tone", music_tone_o, 0);
    chk("t6_rst_en", tone_en_o, 0);
    chk("t6_rst_playing", playing_o, 0);
    chk("t6_rst_toggle", note_toggle_o, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_drain("t6_drain", 50);

    // Flush mid-note with three pairs queued
    push_exp(3, 1, -1);
    tog = n_tog;
    send_byte(8'h03);
    send_byte(8'h05);
    wait_start("t7_start", tog);
    send_byte(8'h08); send_byte(8'h01);
    send_byte(8'h09); send_byte(8'h01);
    send_byte(8'h0A); send_byte(8'h01);
    @(posedge sys_clk); #1;
    uart_data_i = 8'hFF;
    uart_done_i = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("t7_pre_flush_tone", music_tone_o, 3);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("t7_flush_tone", music_tone_o, 0);
    chk("t7_flush_en", tone_en_o, 0);
    uart_done_i = 1'b0;
    tog = n_tog;
    wait_ticks(60);
    chk("t7_no_more_notes", n_tog, tog);
    chk("t7_idle", playing_o, 0);

    repeat (20) @(posedge sys_clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire
